test_table_gen: RTL and testbench



---
 rtl/test_table_pkg.sv | 22 ++
 rtl/test_table_gen_cell_counter.sv | 35 +++
 rtl/test_table_gen.sv | 147 ++++++++++++++
 tb/tb_test_table_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/test_table_pkg.sv
// Shared constants for the table test-pattern generator: default colours,
// pixel class encoding and cell index width.
package test_table_pkg;

  localparam int unsigned IDX_W = 4;

  localparam logic [11:0] BORDER_COLOR_DEF = 12'hFFF;
  localparam logic [11:0] HEADER_COLOR_DEF = 12'h228;
  localparam logic [11:0] FILL_A_DEF       = 12'h444;
  localparam logic [11:0] FILL_B_DEF       = 12'h222;
  localparam logic [11:0] HILITE_COLOR_DEF = 12'hF80;

  typedef enum logic [2:0] {
    CLS_BLANK  = 3'd0,
    CLS_BORDER = 3'd1,
    CLS_HEADER = 3'd2,
    CLS_FILL_A = 3'd3,
    CLS_FILL_B = 3'd4,
    CLS_HILITE = 3'd5
  } pix_class_t;

endpackage

// File: rtl/test_table_gen_cell_counter.sv
// Position-within-cell counter with cell index; wraps at CELL-1, clear wins over increment.
module tt_cell_counter
  import test_table_pkg::*;
#(
  parameter int unsigned CELL = 100,
  parameter int unsigned W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [W-1:0]     pos,
  output logic [IDX_W-1:0] idx
);

  localparam logic [W-1:0] LAST = W'(CELL - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
      idx <= '0;
    end else if (clr) begin
      pos <= '0;
      idx <= '0;
    end else if (inc) begin
      if (pos == LAST) begin
        pos <= '0;
        idx <= idx + 1'b1;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

endmodule

// File: rtl/test_table_gen.sv
// Bordered table / checkerboard pixel generator behind the VGA timing stage.
// Optional cell highlight is enabled with `define TEST_TABLE_HILITE_EN.
module test_table_gen
  import test_table_pkg::*;
#(
  parameter int unsigned H_PIXELS       = 800,
  parameter int unsigned V_LINES        = 600,
  parameter int unsigned PIXEL_GEN_BITS = 12,
  parameter int unsigned CELL_W         = 100,
  parameter int unsigned CELL_H         = 50,
  parameter int unsigned BORDER         = 2,
  parameter logic [11:0] BORDER_COLOR   = BORDER_COLOR_DEF,
  parameter logic [11:0] HEADER_COLOR   = HEADER_COLOR_DEF,
  parameter logic [11:0] FILL_A         = FILL_A_DEF,
  parameter logic [11:0] FILL_B         = FILL_B_DEF
`ifdef TEST_TABLE_HILITE_EN
  ,
  parameter logic [11:0] HILITE_COLOR   = HILITE_COLOR_DEF
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic                      video_on,
  input  logic [PIXEL_GEN_BITS-1:0] pixel_x,
`ifdef TEST_TABLE_HILITE_EN
  input  logic [IDX_W-1:0]          sel_col,
  input  logic [IDX_W-1:0]          sel_row,
`endif
  output logic [11:0]               rgb,
  output logic                      hsync_out,
  output logic                      vsync_out
);

  localparam int unsigned W = PIXEL_GEN_BITS;
  localparam logic [W-1:0] BRD    = W'(BORDER);
  localparam logic [W-1:0] X_EDGE = W'(H_PIXELS - BORDER);
  localparam logic [W-1:0] Y_EDGE = W'(V_LINES - BORDER);

  logic             video_on_d, vsync_d;
  logic             line_end, frame_start;
  logic [W-1:0]     x_in_cell, y_in_cell, y_line;
  logic [IDX_W-1:0] col_idx, row_idx;
  pix_class_t       cls_next, cls_q;
  logic [11:0]      colour;

  assign line_end    = video_on_d & ~video_on;
  assign frame_start = vsync & ~vsync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      video_on_d <= 1'b0;
      vsync_d    <= 1'b0;
    end else begin
      video_on_d <= video_on;
      vsync_d    <= vsync;
    end
  end

  // Horizontal counters run only while active, so they track pixel_x in the same cycle.
  tt_cell_counter #(.CELL(CELL_W), .W(W)) u_h_cnt (
    .clk (clk),
    .rst (rst),
    .clr (~video_on),
    .inc (video_on),
    .pos (x_in_cell),
    .idx (col_idx)
  );

  tt_cell_counter #(.CELL(CELL_H), .W(W)) u_v_cnt (
    .clk (clk),
    .rst (rst),
    .clr (frame_start),
    .inc (line_end),
    .pos (y_in_cell),
    .idx (row_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              y_line <= '0;
    else if (frame_start) y_line <= '0;
    else if (line_end)    y_line <= y_line + 1'b1;
  end

`ifdef TEST_TABLE_HILITE_EN
  logic [IDX_W-1:0] sel_col_q, sel_row_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_col_q <= '1;
      sel_row_q <= '1;
    end else if (frame_start) begin
      sel_col_q <= sel_col;
      sel_row_q <= sel_row;
    end
  end
`endif

  always_comb begin
    cls_next = CLS_BLANK;
    if (video_on) begin
      if (x_in_cell < BRD || y_in_cell < BRD || pixel_x >= X_EDGE || y_line >= Y_EDGE)
        cls_next = CLS_BORDER;
`ifdef TEST_TABLE_HILITE_EN
      else if (row_idx == sel_row_q && col_idx == sel_col_q)
        cls_next = CLS_HILITE;
`endif
      else if (row_idx == '0)
        cls_next = CLS_HEADER;
      else if (row_idx[0] ^ col_idx[0])
        cls_next = CLS_FILL_B;
      else
        cls_next = CLS_FILL_A;
    end
  end

  always_comb begin
    colour = '0;
    case (cls_q)
      CLS_BORDER: colour = BORDER_COLOR;
      CLS_HEADER: colour = HEADER_COLOR;
      CLS_FILL_A: colour = FILL_A;
      CLS_FILL_B: colour = FILL_B;
`ifdef TEST_TABLE_HILITE_EN
      CLS_HILITE: colour = HILITE_COLOR;
`endif
      default:    colour = '0;
    endcase
  end

  // Syncs already lag pixel data by one cycle, so one register realigns them with rgb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q     <= CLS_BLANK;
      rgb       <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      cls_q     <= cls_next;
      rgb       <= colour;
      hsync_out <= hsync;
      vsync_out <= vsync;
    end
  end

endmodule

// File: tb/tb_test_table_gen.sv
// Randomized line/frame stimulus for test_table_gen checked against a per-pixel reference model.
module tb_test_table_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync, vsync, video_on;
  logic [11:0] pixel_x;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;
`ifdef TEST_TABLE_HILITE_EN
  logic [3:0]  sel_col, sel_row;
`endif

  test_table_gen dut (
    .clk       (clk),
    .rst       (rst),
    .hsync     (hsync),
    .vsync     (vsync),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
`ifdef TEST_TABLE_HILITE_EN
    .sel_col   (sel_col),
    .sel_row   (sel_row),
`endif
    .rgb       (rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [11:0] rgb;
    bit          hs;
    bit          vs;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state (timing-stage view of the frame)
  int         line = 0;
  bit         synced = 0;
  bit         on_last = 0, vs_in_last = 0;
  bit         hs_prev = 0, vs_prev = 0;
  logic [3:0] sh_col = 4'hF, sh_row = 4'hF;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h (line %0d)", tag, $time, got, exp, line);
    end
  endtask

  function automatic logic [11:0] ref_pixel(input int x, input int y, input bit on,
                                            input logic [3:0] sc, input logic [3:0] sr);
    int row, col;
    if (!on) return 12'h000;
    row = y / 50;
    col = x / 100;
    if ((x % 100) < 2 || (y % 50) < 2 || x >= 798 || y >= 598) return 12'hFFF;
    if (row == int'(sr) && col == int'(sc)) return 12'hF80;
    if (row == 0) return 12'h228;
    return ((row + col) % 2 != 0) ? 12'h222 : 12'h444;
  endfunction

  // One pixel clock: check the entry from two cycles back, then present the next pixel.
  task automatic step(input bit on, input int p, input bit hs, input bit vs);
    exp_t e;
    bit   vs_in;
    @(posedge clk); #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      if (e.valid) check_val("rgb", 16'(rgb), 16'(e.rgb));
      check_val("hsync_out", 16'(hsync_out), 16'(e.hs));
      check_val("vsync_out", 16'(vsync_out), 16'(e.vs));
    end
    video_on = on;
    pixel_x  = p[11:0];
    hsync    = hs_prev;
    vsync    = vs_prev;
    vs_in    = vs_prev;
    e.valid  = synced || !on;
    e.rgb    = ref_pixel(p, line, on, sh_col, sh_row);
    e.hs     = hs;
    e.vs     = vs;
    q.push_back(e);
    if (vs_in && !vs_in_last) begin
      line   = 0;
      synced = 1;
`ifdef TEST_TABLE_HILITE_EN
      sh_col = sel_col;
      sh_row = sel_row;
`endif
    end else if (on_last && !on) begin
      line++;
    end
    vs_in_last = vs_in;
    on_last    = on;
    hs_prev    = hs;
    vs_prev    = vs;
  endtask

  task automatic run_line(input int act, input int blank, input int hs_lo, input int hs_hi, input bit vs);
    for (int p = 0; p < act + blank; p++)
      step(p < act, p, (p >= hs_lo && p <= hs_hi), vs);
  endtask

  task automatic run_frame(input bit preamble, input bit tight_end, input int n_lines,
                           input bit set_sel, input logic [3:0] c, input logic [3:0] r);
    int act, blk, lo;
    if (preamble)
      for (int v = 0; v < 5; v++) run_line(0, 20, 99, 99, (v == 2 || v == 3));
    for (int l = 0; l < n_lines; l++) begin
`ifdef TEST_TABLE_HILITE_EN
      if (set_sel && l == 300) begin
        sel_col = c;
        sel_row = r;
      end
`else
      if (set_sel && l == 300 && c == r) lo = 0;
`endif
      if (tight_end && l == 599) begin
        // vsync reaches the block on the very cycle the line ends
        for (int p = 0; p < 1056; p++)
          step(p < 800, p, (p >= 840 && p <= 967), p >= 799);
      end else if (l inside {0, 1, 2, 25, 74, 75, 125, 175, 300, 598, 599} ||
                   $urandom_range(0, 99) < 1) begin
        blk = (l == 300 || l == 599) ? 256 : 6;
        run_line(800, blk, (blk == 256) ? 840 : 9999, 967, 1'b0);
      end else begin
        act = $urandom_range(1, 16);
        blk = $urandom_range(2, 5);
        lo  = act + $urandom_range(0, 1);
        run_line(act, blk, lo, lo + $urandom_range(0, 1), 1'b0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; video_on = 1'b0; pixel_x = '0; hsync = 1'b0; vsync = 1'b0;
`ifdef TEST_TABLE_HILITE_EN
    sel_col = 4'h0; sel_row = 4'h0;
`endif
    #1;
    check_val("rst_rgb", 16'(rgb), 16'h0);
    check_val("rst_hsync", 16'(hsync_out), 16'h0);
    check_val("rst_vsync", 16'(vsync_out), 16'h0);
    #20;
    @(posedge clk); #1;
    rst = 1'b0;

    // frame 1: selection changes mid-frame but must not show until the next frame
    run_frame(1'b1, 1'b0, 600, 1'b1, 4'd3, 4'd2);
    // frame 2: highlight visible; ends with vsync rising on a line end
    run_frame(1'b1, 1'b1, 600, 1'b0, 4'd0, 4'd0);
    // frame 3 has no separate vsync: row tracking comes from that collision
    run_frame(1'b0, 1'b0, 120, 1'b0, 4'd0, 4'd0);

    // asynchronous reset in the middle of an active border-row pixel run
    run_line(0, 10, 99, 99, 1'b1);
    run_line(0, 10, 99, 99, 1'b0);
    for (int p = 0; p < 50; p++) step(1'b1, p, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_rgb", 16'(rgb), 16'h0);
    check_val("async_rst_hsync", 16'(hsync_out), 16'h0);
    check_val("async_rst_vsync", 16'(vsync_out), 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    hsync = 1'b0; vsync = 1'b0;
    q.delete();
    line = 0; synced = 0; on_last = 0; vs_in_last = 0;
    hs_prev = 0; vs_prev = 0; sh_col = 4'hF; sh_row = 4'hF;
    for (int p = 50; p < 806; p++) step(p < 800, p, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 60, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
